// File: rtl/fifo_writer_pkg.sv
// fifo_writer_pkg: FSM state encoding and IDT7201 FIFO strobe/flag polarities,
// shared by the FIFO writer here and the FIFO reader in the display device.
package fifo_writer_pkg;

    typedef enum logic [2:0] {
        RS_HOLD = 3'd0,
        RS_REC  = 3'd1,
        IDLE    = 3'd2,
        SETUP   = 3'd3,
        STROBE  = 3'd4,
        RECOVER = 3'd5
    } wr_state_t;

    // -W, -RS and -FF are all active-low on the IDT7201
    localparam logic W_ASSERT    = 1'b0;
    localparam logic W_DEASSERT  = 1'b1;
    localparam logic RS_ASSERT   = 1'b0;
    localparam logic RS_DEASSERT = 1'b1;
    localparam logic FF_FULL     = 1'b0;
    localparam logic FF_NOT_FULL = 1'b1;

endpackage

// File: rtl/fifo_writer_if.sv
// fifo_writer_if: byte handshake from command logic plus the external FIFO bus.
//   in_data/in_valid/in_ready : valid/ready byte transfer into the writer
//   fifo_q/fifo_w/fifo_rs     : FIFO data bus, -W strobe, -RS reset (active-low)
//   fifo_ff                   : -FF full flag from the FIFO (active-low, async)
// master = the writer, slave = command logic and the FIFO device.
interface fifo_writer_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] fifo_q;
    logic       fifo_w;
    logic       fifo_rs;
    logic       fifo_ff;

    modport master (
        input  in_data, in_valid, fifo_ff,
        output in_ready, fifo_q, fifo_w, fifo_rs
    );

    modport slave (
        output in_data, in_valid, fifo_ff,
        input  in_ready, fifo_q, fifo_w, fifo_rs
    );

endinterface

// File: rtl/fifo_writer_sync2.sv
// fifo_writer_sync2: two-flop synchronizer for an asynchronous single-bit input.
//   clk, rst : clock and async active-low reset (both flops load RST_VAL)
//   d_i      : asynchronous input
//   q_o      : synchronized output, two clk cycles of latency
module fifo_writer_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/fifo_writer.sv
// fifo_writer: queues bytes from command logic and writes them into an
// IDT7201-style FIFO with timed -W strobes, stalling while -FF reports full.
//   clk, rst : clock and async active-low reset
//   bus      : master side of fifo_writer_if (byte handshake + FIFO bus)
//   busy     : queue non-empty or a write in progress
//   level    : internal queue occupancy
module fifo_writer
    import fifo_writer_pkg::*;
#(
    parameter int WR_LOW_TICKS  = 3,
    parameter int WR_HIGH_TICKS = 3,
    parameter int RS_TICKS      = 4,
    parameter int QDEPTH_LOG2   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_writer_if.master        bus,
    output logic                 busy,
    output logic [QDEPTH_LOG2:0] level
);

    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam logic [7:0] RS_LAST   = 8'(RS_TICKS - 1);
    localparam logic [7:0] LOW_LAST  = 8'(WR_LOW_TICKS - 1);
    localparam logic [7:0] HIGH_LAST = 8'(WR_HIGH_TICKS - 1);
    localparam logic [QDEPTH_LOG2:0]   LVL_FULL = {1'b1, {QDEPTH_LOG2{1'b0}}};
    localparam logic [QDEPTH_LOG2:0]   LVL_ONE  = (QDEPTH_LOG2 + 1)'(1);
    localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);

    wr_state_t              state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [7:0]             q_q, q_d;
    logic                   w_q, rs_q, rdy_q;
    logic [QDEPTH_LOG2:0]   lvl_q, lvl_d;
    logic [QDEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]             mem_q [DEPTH];
    logic [7:0]             head;
    logic                   ff_s, push, pop;

    fifo_writer_sync2 #(.RST_VAL(FF_NOT_FULL)) u_ff_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.fifo_ff),
        .q_o (ff_s)
    );

    assign head = mem_q[rd_ptr_q];
    assign push = bus.in_valid && rdy_q;
    // the byte leaves the queue on the edge where -W goes back high
    assign pop  = state_q == STROBE && cnt_q == LOW_LAST;
    assign lvl_d = lvl_q + (push ? LVL_ONE : '0) - (pop ? LVL_ONE : '0);

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        case (state_q)
            RS_HOLD: state_d = cnt_q == RS_LAST ? RS_REC : RS_HOLD;
            RS_REC:  state_d = IDLE;
            IDLE: begin
                state_d = lvl_q != '0 ? SETUP : IDLE;
                q_d     = lvl_q != '0 ? head : q_q;
            end
            SETUP:   state_d = ff_s != FF_FULL ? STROBE : SETUP;
            STROBE:  state_d = cnt_q == LOW_LAST ? RECOVER : STROBE;
            RECOVER: begin
                // lvl_q already excludes the byte just written
                state_d = cnt_q != HIGH_LAST ? RECOVER : lvl_q != '0 ? SETUP : IDLE;
                q_d     = cnt_q == HIGH_LAST && lvl_q != '0 ? head : q_q;
            end
            default: state_d = RS_HOLD;
        endcase
        // counter restarts at every state change; free-running wrap in IDLE/SETUP is harmless
        cnt_d = state_d == state_q ? cnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RS_HOLD;
            cnt_q    <= '0;
            q_q      <= '0;
            w_q      <= W_DEASSERT;
            rs_q     <= RS_ASSERT;
            rdy_q    <= 1'b0;
            lvl_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_q      <= q_d;
            // strobes are decoded from the next state so they come straight off flops
            w_q      <= state_d == STROBE ? W_ASSERT : W_DEASSERT;
            rs_q     <= state_d == RS_HOLD ? RS_ASSERT : RS_DEASSERT;
            // registered ready: a pop while full re-opens the queue one cycle later
            rdy_q    <= !(state_q inside {RS_HOLD, RS_REC}) && lvl_d != LVL_FULL;
            lvl_q    <= lvl_d;
            wr_ptr_q <= push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.in_ready = rdy_q;
    assign bus.fifo_q   = q_q;
    assign bus.fifo_w   = w_q;
    assign bus.fifo_rs  = rs_q;
    assign busy         = lvl_q != '0 || state_q inside {SETUP, STROBE, RECOVER};
    assign level        = lvl_q;

endmodule

// File: tb/tb_fifo_writer.sv
// tb_fifo_writer: cycle table for reset and a single write, directed corner
// sequences, and a randomized run against a queue model of the bytes and of
// the external FIFO fill level.
module tb_fifo_writer;

    localparam int WL  = 3;
    localparam int WH  = 3;
    localparam int CAP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [2:0] level;

    fifo_writer_if bus();

    fifo_writer #(
        .WR_LOW_TICKS  (WL),
        .WR_HIGH_TICKS (WH),
        .RS_TICKS      (4),
        .QDEPTH_LOG2   (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .level (level)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0, errors = 0, cyc = 0;
    int falls = 0, rises = 0, low_run = 0, high_run = 0;
    logic prev_w = 1'b1;
    bit seen_rise = 0, model_on = 0;
    int ext_n = 0, acc = 0, wr_n = 0;
    logic [7:0] wr_log[$];
    logic [7:0] exp_q[$];
    int fall_cyc[$];

    typedef struct {
        bit         r;
        bit         v;
        bit [7:0]   d;
        logic [14:0] e;
    } vec_t;

    vec_t tv[16];

    function automatic vec_t mk(input bit r, input bit v, input bit [7:0] d, input bit rs,
                                input bit w, input bit rdy, input bit [2:0] lvl, input bit bsy,
                                input bit [7:0] q);
        mk.r = r;
        mk.v = v;
        mk.d = d;
        mk.e = {rs, w, rdy, lvl, bsy, q};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // advance to the next falling edge and watch the FIFO bus for strobes
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!rst) begin
            prev_w = 1'b1;
            seen_rise = 0;
            low_run = 0;
            return;
        end
        chk("w_rs_exclusive", bus.fifo_w | bus.fifo_rs, 1);
        if (!prev_w && bus.fifo_w) begin
            rises++;
            wr_log.push_back(bus.fifo_q);
            chk("low_width", low_run, WL);
            seen_rise = 1;
            high_run = 0;
            if (model_on) begin
                wr_n++;
                ext_n++;
                chk("ext_no_overflow", ext_n <= CAP, 1);
                chk("write_order", bus.fifo_q, exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'h100);
            end
        end
        if (prev_w && !bus.fifo_w) begin
            falls++;
            fall_cyc.push_back(cyc);
            if (seen_rise) chk("high_gap", high_run >= WH + 1, 1);
            low_run = 0;
        end
        if (bus.fifo_w) high_run++;
        else low_run++;
        prev_w = bus.fifo_w;
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("push_ready_timeout", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (rises < n && k < budget) begin
            tick();
            k++;
        end
        chk("rise_timeout", rises >= n, 1);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k = 0;
        while (falls < n && k < budget) begin
            tick();
            k++;
        end
        chk("fall_timeout", falls >= n, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int r0, f0, w0, c, k;
        logic [7:0] b2b[4];
        b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33; b2b[3] = 8'h44;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.fifo_ff = 1'b1;

        // reset release then a single 0xA5 write; e = {rs, w, rdy, level, busy, q}
        tv[0]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tv[1]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tv[2]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tv[3]  = mk(1, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        tv[4]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        tv[5]  = mk(1, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00);
        tv[6]  = mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00);
        tv[7]  = mk(1, 1, 8'hA5, 1, 1, 1, 1, 1, 8'h00);
        tv[8]  = mk(1, 0, 8'h00, 1, 1, 1, 1, 1, 8'hA5);
        tv[9]  = mk(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA5);
        tv[10] = mk(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA5);
        tv[11] = mk(1, 0, 8'h00, 1, 0, 1, 1, 1, 8'hA5);
        tv[12] = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'hA5);
        tv[13] = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'hA5);
        tv[14] = mk(1, 0, 8'h00, 1, 1, 1, 0, 1, 8'hA5);
        tv[15] = mk(1, 0, 8'h00, 1, 1, 1, 0, 0, 8'hA5);

        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            rst = tv[i].r;
            bus.in_valid = tv[i].v;
            bus.in_data = tv[i].d;
            tick();
            chk($sformatf("vec%0d", i), {bus.fifo_rs, bus.fifo_w, bus.in_ready, level, busy, bus.fifo_q}, 32'(tv[i].e));
        end
        chk("a5_written", wr_log.size() == 1 ? 32'(wr_log[0]) : 32'h100, 8'hA5);

        // four back-to-back pushes fill the queue
        r0 = rises; f0 = fall_cyc.size(); w0 = wr_log.size();
        for (int i = 0; i < 4; i++) push(b2b[i]);
        chk("b2b_ready_full", bus.in_ready, 0);
        chk("b2b_level_full", level, 4);
        k = 0;
        while (rises - r0 < 4 && k < 60) begin
            c = rises;
            tick();
            k++;
            if (rises != c) chk("b2b_level_at_rise", level, 4 - (rises - r0));
        end
        chk("b2b_count", rises - r0, 4);
        for (int i = 0; i < 4; i++)
            chk("b2b_byte", wr_log.size() > w0 + i ? 32'(wr_log[w0 + i]) : 32'h100, b2b[i]);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", fall_cyc.size() > f0 + i ? fall_cyc[f0 + i] - fall_cyc[f0 + i - 1] : -1, 7);
        wait_idle();

        // FIFO full before two bytes arrive: writer parks in SETUP
        bus.fifo_ff = 1'b0;
        repeat (3) tick();
        r0 = rises;
        push(8'h5A);
        push(8'hC3);
        f0 = falls;
        repeat (20) tick();
        chk("ffhold_no_strobe", falls, f0);
        chk("ffhold_level", level, 2);
        chk("ffhold_q", bus.fifo_q, 8'h5A);
        chk("ffhold_busy", busy, 1);
        bus.fifo_ff = 1'b1;
        c = cyc;
        wait_falls(f0 + 1, 10);
        chk("ffhold_release_latency", fall_cyc[$] - c <= 3, 1);
        wait_rises(r0 + 2, 40);
        chk("ffhold_byte0", wr_log[$ - 1], 8'h5A);
        chk("ffhold_byte1", wr_log[$], 8'hC3);
        chk("ffhold_cadence", fall_cyc[$] - fall_cyc[$ - 1], 7);
        wait_idle();

        // FIFO goes full right as the first write commits
        r0 = rises;
        push(8'h77);
        push(8'h88);
        wait_rises(r0 + 1, 30);
        bus.fifo_ff = 1'b0;
        f0 = falls;
        repeat (15) tick();
        chk("ffedge_no_strobe", falls, f0);
        chk("ffedge_level", level, 1);
        bus.fifo_ff = 1'b1;
        wait_rises(r0 + 2, 30);
        chk("ffedge_byte", wr_log[$], 8'h88);
        wait_idle();

        // reset in the second STROBE cycle
        push(8'h99);
        push(8'h66);
        wait_falls(falls + 1, 20);
        tick();
        chk("rstmid_w_low", bus.fifo_w, 0);
        rst = 1'b0;
        #1;
        chk("rstmid_w", bus.fifo_w, 1);
        chk("rstmid_rs", bus.fifo_rs, 0);
        chk("rstmid_level", level, 0);
        chk("rstmid_ready", bus.in_ready, 0);
        r0 = rises;
        tick();
        tick();
        rst = 1'b1;
        k = 0;
        while (!bus.fifo_rs && k < 20) begin
            tick();
            k++;
        end
        chk("rstmid_rs_repeat", k, 4);
        repeat (30) tick();
        chk("rstmid_no_stale", rises, r0);
        chk("rstmid_level_after", level, 0);
        chk("rstmid_ready_after", bus.in_ready, 1);

        // randomized traffic against the queue / external FIFO model
        model_on = 1;
        ext_n = 0;
        acc = 0;
        wr_n = 0;
        exp_q.delete();
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = $urandom_range(0, 2) != 0;
            bus.in_data = 8'($urandom);
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(bus.in_data);
                acc++;
            end
            tick();
            chk("rnd_level", level, acc - wr_n);
            chk("rnd_ready", bus.in_ready, level != 3'd4);
            if (ext_n > 0 && $urandom_range(0, 11) == 0) ext_n--;
            bus.fifo_ff = ext_n < CAP;
        end
        bus.in_valid = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 600) begin
            tick();
            k++;
            if (ext_n > 0 && $urandom_range(0, 3) == 0) ext_n--;
            bus.fifo_ff = ext_n < CAP;
        end
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_final_level", level, 0);
        chk("rnd_write_count", wr_n, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_writer.md
Name: fifo_writer

Overview:
- Producer end of the IDT7201-style FIFO that feeds the display device. Writes bytes into the external FIFO via its active-low -W strobe, honouring the -FF full flag.
- Accepts bytes from on-chip command logic through a valid/ready handshake and buffers them in a small internal queue.
- Generates the FIFO -RS reset pulse after system reset.

Parameters:
- WR_LOW_TICKS, 3, clk cycles -W is held low per write; range 1..255.
- WR_HIGH_TICKS, 3, clk cycles -W is held high after each write (recovery and flag settle); range 3..255.
- RS_TICKS, 4, clk cycles -RS is held low after reset release; range 1..255.
- QDEPTH_LOG2, 2, log2 of internal queue depth (default 4 entries).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  byte to write
- in_valid  in  1  in_data valid
- in_ready  out  1  queue can accept; transfer when in_valid && in_ready at posedge clk
- fifo_q  out  8  data bus to FIFO D inputs
- fifo_w  out  1  -W strobe to FIFO, active-low
- fifo_rs  out  1  -RS to FIFO, active-low
- fifo_ff  in  1  -FF from FIFO, active-low, asynchronous to clk
- busy  out  1  high when queue non-empty or a write is in progress
- level  out  QDEPTH_LOG2+1  queue occupancy

Behaviour:
- Reset (rst low, async):
  - fifo_rs=0, fifo_w=1, fifo_q=0, in_ready=0, busy=0, level=0.
  - Queue pointers cleared; state=RS_HOLD; tick counter=0.
- fifo_ff passes through a 2-flop synchronizer; ff_s is the synchronized value. It is reset to 1 (not full).
- FSM states:
  - RS_HOLD: fifo_rs=0. After RS_TICKS cycles with rst high, go to RS_REC.
  - RS_REC: fifo_rs=1 for one cycle, then go to IDLE. in_ready is 0 in RS_HOLD and RS_REC.
  - IDLE: if queue non-empty, drive fifo_q=queue head and go to SETUP.
  - SETUP: fifo_q stable, fifo_w=1. If ff_s==1, go to STROBE. If ff_s==0 (full), stay in SETUP indefinitely with fifo_w high.
  - STROBE: fifo_w=0 for exactly WR_LOW_TICKS cycles, then go to RECOVER. The queue head is popped on the cycle fifo_w returns high (write commits on the -W rising edge).
  - RECOVER: fifo_w=1 for WR_HIGH_TICKS cycles; fifo_q holds the written byte (hold time). Then go to SETUP with the next head if the queue is non-empty, else IDLE.
- fifo_ff is sampled only in SETUP. Once STROBE starts, the write always completes.
- WR_HIGH_TICKS>=3 guarantees ff_s reflects a flag change caused by the previous write before the next SETUP decision.
- Single-byte latency: push at cycle N, SETUP at N+1 (IDLE->SETUP), fifo_w falls at N+2, rises at N+2+WR_LOW_TICKS.
- Back-to-back throughput: one byte per 1+WR_LOW_TICKS+WR_HIGH_TICKS cycles (SETUP counts as one cycle).
- Queue:
  - Circular buffer, 2^QDEPTH_LOG2 entries.
  - in_ready = !full && state not in {RS_HOLD, RS_REC}.
  - A pop in the same cycle as full does not raise in_ready until the next cycle.
  - Simultaneous push and pop when non-full: level unchanged.
  - Pointers wrap modulo depth; level saturates only at depth by construction.
- fifo_w and fifo_rs are registered outputs, glitch-free, and never low in the same cycle.
- Reset asserted mid-STROBE: fifo_w returns to 1 immediately (async), the queue is discarded, and fifo_rs is asserted.

Decomposition:
- Shared package/header: FSM state encodings (RS_HOLD, RS_REC, IDLE, SETUP, STROBE, RECOVER; 3 bits) and FIFO signal polarity constants shared with the FIFO reader in the display device.
- One sub-module: sync2 (2-flop synchronizer with async active-low reset and parameterized reset value), reused for fifo_ff and future async inputs.

Test Plan:
- Reset release -> fifo_rs low for exactly 4 cycles, high thereafter; in_ready rises 2 cycles after fifo_rs rises; fifo_w stays 1 throughout.
- Push 0xA5 with fifo_ff=1 -> fifo_q=0xA5, fifo_w low 3 cycles starting 2 cycles after the push; fifo_q still 0xA5 for 3 cycles after the -W rising edge; level returns to 0; busy drops.
- Push 0x11,0x22,0x33,0x44 back-to-back -> in_ready drops after the 4th push; four -W pulses spaced 7 cycles apart carry the bytes in order; level decrements at each -W rising edge.
- Hold fifo_ff=0 with 2 bytes queued -> no -W pulse, state stays SETUP. Release fifo_ff=1 -> first pulse within 3 cycles of release (sync + SETUP), then normal cadence.
- Set fifo_ff=0 coinciding with the first -W rising edge -> the second byte is not strobed until fifo_ff=1 again (validates WR_HIGH_TICKS>=3 covers synchronizer latency).
- Assert rst during the 2nd STROBE cycle -> fifo_w=1 and fifo_rs=0 the same cycle, level=0. After release, the reset sequence repeats and no stale byte is written.
